// File: rtl/aib_calib_master_seq.sv
// aib_calib_master_seq: master-side AIB DCC/DLL lock handshake with per-wait timeout, backoff and bounded retry.
// Define AIB_CALIB_SEQ_CHNL_MASK_EN to add the chnl_mask input that excludes channels from the handshake.
module aib_calib_master_seq #(
    parameter int TOTAL_CHNL_NUM = 24,
    parameter int TIMEOUT_CYC    = 1024,
    parameter int BACKOFF_CYC    = 16,
    parameter int MAX_RETRY      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      i_conf_done,
    input  logic [TOTAL_CHNL_NUM-1:0] ns_mac_rdy,
    input  logic [TOTAL_CHNL_NUM-1:0] sl_rx_dcc_dll_lock_req,
    input  logic [TOTAL_CHNL_NUM-1:0] sl_tx_dcc_dll_lock_req,
    input  logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en,
    input  logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en,
`ifdef AIB_CALIB_SEQ_CHNL_MASK_EN
    input  logic [TOTAL_CHNL_NUM-1:0] chnl_mask,
`endif
    output logic [TOTAL_CHNL_NUM-1:0] ms_rx_dcc_dll_lock_req,
    output logic [TOTAL_CHNL_NUM-1:0] ms_tx_dcc_dll_lock_req,
    output logic                      busy,
    output logic                      calib_done,
    output logic                      calib_fail,
    output logic [3:0]                retry_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int BW = $clog2(BACKOFF_CYC + 1);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, REQ, WAIT_ACK, WAIT_XFER, BACKOFF, DONE, FAIL} state_t;

    state_t                    state, nxt, to_nxt;
    logic [TW-1:0]             tmr;
    logic [BW-1:0]             bo_cnt;
    logic [TOTAL_CHNL_NUM-1:0] active, req;
    logic                      rdy_ok, ack_ok, xfer_ok, no_chnl, to, bo_done;

`ifdef AIB_CALIB_SEQ_CHNL_MASK_EN
    assign active = chnl_mask;
`else
    assign active = '1;
`endif

    // masked channels read as set so they never block a wait state
    assign rdy_ok  = i_conf_done && &(ns_mac_rdy | ~active);
    assign ack_ok  = &((sl_rx_dcc_dll_lock_req & sl_tx_dcc_dll_lock_req) | ~active);
    assign xfer_ok = &((sl_rx_transfer_en & sl_tx_transfer_en) | ~active);
    assign no_chnl = ~|active;
    assign to      = tmr == TW'(TIMEOUT_CYC - 1);
    assign bo_done = bo_cnt == BW'(BACKOFF_CYC - 1);
    assign to_nxt  = (retry_cnt < 4'(MAX_RETRY)) ? BACKOFF : FAIL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = start ? WAIT_RDY : IDLE;
            WAIT_RDY:  nxt = no_chnl ? FAIL : rdy_ok ? REQ : to ? to_nxt : WAIT_RDY;
            REQ:       nxt = WAIT_ACK;
            WAIT_ACK:  nxt = ack_ok ? WAIT_XFER : to ? to_nxt : WAIT_ACK;
            WAIT_XFER: nxt = xfer_ok ? DONE : to ? to_nxt : WAIT_XFER;
            BACKOFF:   nxt = bo_done ? WAIT_RDY : BACKOFF;
            DONE:      nxt = start ? WAIT_RDY : DONE;
            FAIL:      nxt = start ? WAIT_RDY : FAIL;
            default:   nxt = IDLE;
        endcase
    end

    // timer restarts on every state change and saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr       <= '0;
            bo_cnt    <= '0;
            retry_cnt <= '0;
            req       <= '0;
        end else begin
            tmr       <= (nxt != state) ? '0 : (&tmr) ? tmr : tmr + 1'b1;
            bo_cnt    <= (state == BACKOFF) ? bo_cnt + 1'b1 : '0;
            retry_cnt <= (nxt == WAIT_RDY && state inside {IDLE, DONE, FAIL}) ? 4'd0 :
                         (nxt == BACKOFF && state != BACKOFF) ? retry_cnt + 4'd1 : retry_cnt;
            req       <= (nxt inside {WAIT_ACK, WAIT_XFER, DONE}) ? active : '0;
        end
    end

    always_comb begin
        busy                   = !(state inside {IDLE, DONE, FAIL});
        calib_done             = state == DONE;
        calib_fail             = state == FAIL;
        ms_rx_dcc_dll_lock_req = req;
        ms_tx_dcc_dll_lock_req = req;
    end
endmodule

// File: tb/tb_aib_calib_master_seq.sv
// tb_aib_calib_master_seq: directed checks of the calibration sequencer (TIMEOUT_CYC=32, BACKOFF_CYC=16, MAX_RETRY=3).
module tb_aib_calib_master_seq;
    localparam int N = 24;
    localparam logic [N-1:0] ONES = '1;
    localparam logic [N-1:0] NO23 = 24'h7FFFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic i_conf_done = 1'b0;
    logic [N-1:0] ns_mac_rdy = '0;
    logic [N-1:0] sl_rx_lock = '0, sl_tx_lock = '0, sl_rx_xfer = '0, sl_tx_xfer = '0;
    logic [N-1:0] chnl_mask = '1;
    logic [N-1:0] ms_rx, ms_tx;
    logic busy, calib_done, calib_fail;
    logic [3:0] retry_cnt;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    aib_calib_master_seq #(
        .TOTAL_CHNL_NUM(N), .TIMEOUT_CYC(32), .BACKOFF_CYC(16), .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .i_conf_done(i_conf_done),
        .ns_mac_rdy(ns_mac_rdy),
        .sl_rx_dcc_dll_lock_req(sl_rx_lock),
        .sl_tx_dcc_dll_lock_req(sl_tx_lock),
        .sl_rx_transfer_en(sl_rx_xfer),
        .sl_tx_transfer_en(sl_tx_xfer),
`ifdef AIB_CALIB_SEQ_CHNL_MASK_EN
        .chnl_mask(chnl_mask),
`endif
        .ms_rx_dcc_dll_lock_req(ms_rx),
        .ms_tx_dcc_dll_lock_req(ms_tx),
        .busy(busy),
        .calib_done(calib_done),
        .calib_fail(calib_fail),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
    endtask

    task automatic slave(input logic rdy, input logic [N-1:0] rx_lock, input logic [N-1:0] lock_tx,
                         input logic [N-1:0] xfer);
        i_conf_done = rdy;
        ns_mac_rdy  = rdy ? ONES : '0;
        sl_rx_lock  = rx_lock;
        sl_tx_lock  = lock_tx;
        sl_rx_xfer  = xfer;
        sl_tx_xfer  = xfer;
    endtask

    initial begin
        step();
        step();
        chk("rst_req", ms_rx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {calib_done, calib_fail, retry_cnt}, 0);
        rst_n = 1'b1;
        step();

        // nominal: ready at once, acks 5 cycles after requests, transfer 2 cycles after acks
        slave(1'b1, '0, '0, '0);
        pulse_start();
        chk("nom_busy_c1", busy, 1);
        chk("nom_req_c1", ms_rx, 0);
        step();
        chk("nom_req_c2", ms_tx, 0);
        step();
        chk("nom_rx_req_c3", ms_rx, ONES);
        chk("nom_tx_req_c3", ms_tx, ONES);
        to_cyc(8);
        slave(1'b1, ONES, ONES, '0);
        to_cyc(10);
        sl_rx_xfer = ONES;
        sl_tx_xfer = ONES;
        chk("nom_done_c10", calib_done, 0);
        step();
        chk("nom_done_c11", calib_done, 1);
        chk("nom_busy_c11", busy, 0);
        chk("nom_retry", retry_cnt, 0);

        // sticky done after slave drops everything
        slave(1'b0, '0, '0, '0);
        step();
        step();
        step();
        chk("sticky_done", calib_done, 1);
        chk("sticky_req", ms_rx, ONES);

        // partial ack restarted from DONE: channel 23 rx ack never arrives
        slave(1'b1, NO23, ONES, ONES);
        pulse_start();
        chk("rs_req_c1", ms_rx, 0);
        chk("rs_done_c1", calib_done, 0);
        chk("rs_busy_c1", busy, 1);
        to_cyc(3);
        chk("pa_req_c3", ms_rx, ONES);
        to_cyc(34);
        chk("pa_req_c34", ms_rx, ONES);
        chk("pa_retry_c34", retry_cnt, 0);
        step();
        chk("pa_req_c35", ms_tx, 0);
        chk("pa_retry_c35", retry_cnt, 1);
        chk("pa_busy_c35", busy, 1);
        to_cyc(50);
        chk("pa_req_c50", ms_rx, 0);
        step();
        chk("pa_req_c51", ms_rx, 0);
        to_cyc(53);
        chk("pa_req_c53", ms_rx, ONES);
        to_cyc(85);
        chk("pa_retry_c85", retry_cnt, 2);
        chk("pa_req_c85", ms_rx, 0);
        to_cyc(135);
        chk("pa_retry_c135", retry_cnt, 3);
        to_cyc(184);
        chk("pa_fail_c184", calib_fail, 0);
        step();
        chk("pa_fail_c185", calib_fail, 1);
        chk("pa_retry_c185", retry_cnt, 3);
        chk("pa_busy_c185", busy, 0);
        chk("pa_req_c185", ms_rx, 0);

        // recovery from FAIL: channel 23 acks during the second attempt
        pulse_start();
        chk("rc_fail_c1", calib_fail, 0);
        chk("rc_retry_c1", retry_cnt, 0);
        to_cyc(60);
        sl_rx_lock = ONES;
        step();
        chk("rc_done_c61", calib_done, 0);
        step();
        chk("rc_done_c62", calib_done, 1);
        chk("rc_retry_c62", retry_cnt, 1);

        // boundary: ack completes on the last timer cycle, exit beats timeout
        slave(1'b1, NO23, ONES, ONES);
        pulse_start();
        to_cyc(34);
        sl_rx_lock = ONES;
        step();
        chk("bd_retry_c35", retry_cnt, 0);
        chk("bd_req_c35", ms_rx, ONES);
        step();
        chk("bd_done_c36", calib_done, 1);

        // asynchronous reset in WAIT_ACK
        slave(1'b1, NO23, ONES, ONES);
        pulse_start();
        to_cyc(5);
        chk("ar_req_pre", ms_rx, ONES);
        rst_n = 1'b0;
        #1;
        chk("ar_req", ms_rx, 0);
        chk("ar_tx_req", ms_tx, 0);
        chk("ar_busy", busy, 0);
        chk("ar_flags", {calib_done, calib_fail, retry_cnt}, 0);
        rst_n = 1'b1;
        step();
        slave(1'b1, ONES, ONES, ONES);
        pulse_start();
        to_cyc(3);
        chk("ar2_req_c3", ms_rx, ONES);
        step();
        chk("ar2_done_c4", calib_done, 0);
        step();
        chk("ar2_done_c5", calib_done, 1);

`ifdef AIB_CALIB_SEQ_CHNL_MASK_EN
        // only channels 0..15 enabled; upper channels never ack
        chnl_mask = 24'h00FFFF;
        slave(1'b1, 24'h00FFFF, 24'h00FFFF, 24'h00FFFF);
        pulse_start();
        to_cyc(3);
        chk("mk_req_c3", ms_rx, 24'h00FFFF);
        to_cyc(5);
        chk("mk_done_c5", calib_done, 1);
        chk("mk_req_c5", ms_tx, 24'h00FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aib_calib_master_seq.md
# aib_calib_master_seq

Master-side AIB calibration sequencer. It drives the per-channel DCC/DLL lock requests toward the slave calibration FSM and waits for the slave to answer across all channels. It bounds each wait with a timeout and re-issues the handshake up to a retry limit. It sits beside the slave calibration FSM in the AXI-Lite AIB example and gates link bring-up with `calib_done` and `calib_fail`.

## Interface
- `TOTAL_CHNL_NUM`, 24, channel count; all per-channel vectors use this width.
- `TIMEOUT_CYC`, 1024, wait budget in cycles per wait state; must be ≥ 2.
- `BACKOFF_CYC`, 16, idle cycles between a timeout and the re-request; must be ≥ 1.
- `MAX_RETRY`, 3, re-requests allowed after the first attempt; 0..15.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle pulse that starts or restarts calibration.
- `i_conf_done`  in  1  slave configuration done.
- `ns_mac_rdy`  in  TOTAL_CHNL_NUM  slave MAC ready, per channel.
- `sl_rx_dcc_dll_lock_req`, `sl_tx_dcc_dll_lock_req`  in  TOTAL_CHNL_NUM each  slave lock acknowledges.
- `sl_rx_transfer_en`, `sl_tx_transfer_en`  in  TOTAL_CHNL_NUM each  slave transfer enables.
- `ms_rx_dcc_dll_lock_req`, `ms_tx_dcc_dll_lock_req`  out  TOTAL_CHNL_NUM each  master lock requests.
- `busy`  out  1  high in every state except IDLE, DONE and FAIL.
- `calib_done`  out  1  calibration succeeded; level signal.
- `calib_fail`  out  1  retries exhausted; level signal.
- `retry_cnt`  out  4  retries used in the current run.

## Operation
- States: IDLE, WAIT_RDY, REQ, WAIT_ACK, WAIT_XFER, BACKOFF, DONE, FAIL.
- "All set" for a vector means every channel in the active set is 1. Without the macro, the active set is all channels.
- IDLE: `start` → WAIT_RDY. The timer and `retry_cnt` clear on this transition.
- WAIT_RDY: when `i_conf_done` is high and `ns_mac_rdy` is all set → REQ.
- REQ: lasts one cycle. The timer clears. Go to WAIT_ACK.
- The `ms_*_req` outputs are registered. They are driven to all ones (active set only) from the cycle after entering REQ, and stay there through WAIT_ACK, WAIT_XFER and DONE.
- WAIT_ACK: when both `sl_*_dcc_dll_lock_req` vectors are all set, the timer clears → WAIT_XFER.
- WAIT_XFER: when both `sl_*_transfer_en` vectors are all set → DONE.
- Timeout applies in WAIT_RDY, WAIT_ACK and WAIT_XFER. It fires when the timer equals `TIMEOUT_CYC-1` and the exit condition is false that cycle. If the exit condition is true in the same cycle, the exit wins.
- On timeout:
  - if `retry_cnt` < `MAX_RETRY`: increment `retry_cnt`, drop the `ms_*_req` outputs to 0, go to BACKOFF;
  - otherwise go to FAIL.
- BACKOFF: counts `BACKOFF_CYC` cycles, then → WAIT_RDY. The timer clears on this transition.
- DONE: `calib_done` = 1.
- FAIL: `calib_fail` = 1 and the requests are 0.
- `start` in DONE or FAIL restarts the run exactly as from IDLE: requests drop to 0 and the done/fail flags clear the next cycle.
- `start` is ignored in all other states.
- Deassertion of any slave input after DONE does not change the state (sticky done).
- The timer is sized `$clog2(TIMEOUT_CYC)` bits and saturates; it never wraps.

## Timing
- Reset values: all outputs 0, state IDLE. Reset mid-run aborts immediately and asynchronously; requests drop to 0 with no handshake.
- `start` at cycle 0 → `busy` = 1 at cycle 1.
- With the slave already ready, the requests assert at cycle 3 (cycle 1 WAIT_RDY, cycle 2 REQ, registered outputs).
- Acks all set at cycle N → state WAIT_XFER at N+1. Transfer enables all set at cycle M ≥ N+1 → `calib_done` at M+1.
- Timeout at cycle T → requests 0 at T+1, BACKOFF spans T+1..T+BACKOFF_CYC, WAIT_RDY at T+BACKOFF_CYC+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `AIB_CALIB_SEQ_CHNL_MASK_EN` defined: adds input `chnl_mask` (TOTAL_CHNL_NUM, 1 = channel enabled), sampled every cycle.
  - Masked channels are excluded from every "all set" check, and their `ms_*_req` bits are held 0.
  - If `chnl_mask` is all zero while in WAIT_RDY → FAIL on the next cycle, without using a retry.
- Macro undefined: there is no port, and all channels are enabled.

## Test plan
- Nominal: after reset, pulse `start`; the slave model raises readiness at once, acks 5 cycles after the requests, and transfer enables 2 cycles after the acks → requests high at cycle 3, `calib_done` = 1, `retry_cnt` = 0, `busy` = 0.
- Partial ack: channel 23 `sl_rx` lock ack held 0, TIMEOUT_CYC = 32, MAX_RETRY = 3 → three BACKOFF episodes of 16 cycles each with requests low, then FAIL, `calib_fail` = 1, `retry_cnt` = 3.
- Recovery: as the partial-ack case, but channel 23 acks during the second attempt → DONE with `retry_cnt` = 1.
- Boundary: ack becomes all set exactly at timer = TIMEOUT_CYC-1 → WAIT_XFER, no retry counted.
- Reset and restart: assert `rst_n` low during WAIT_ACK → all outputs 0 within the same cycle. Then pulse `start` in DONE → requests 0 and `calib_done` 0 next cycle, new run completes.
- Mask (macro on): `chnl_mask` = 24'h00FFFF, channels 16..23 never ack → DONE, and `ms_*_req[23:16]` stay 0 throughout.
